// File: rtl/vu_level_meter_if.sv
// ADC serial bus and level outputs of the VU level meter.
// The meter is the master; the ADC and display side are the slave.
interface vu_level_meter_if;
    logic        adc_miso;
    logic        adc_sclk;
    logic        adc_cs_n;
    logic [11:0] sample;
    logic [7:0]  level;
    logic        level_valid;

    modport master (
        input  adc_miso,
        output adc_sclk,
        output adc_cs_n,
        output sample,
        output level,
        output level_valid
    );

    modport slave (
        output adc_miso,
        input  adc_sclk,
        input  adc_cs_n,
        input  sample,
        input  level,
        input  level_valid
    );
endinterface

// File: rtl/vu_level_meter.sv
// Serial ADC reader with rectifier and peak-hold/decay envelope.
// Feeds an 8-bit level to the VGA display stage.
module vu_level_meter #(
    parameter int unsigned CLK_DIV       = 4,
    parameter int unsigned SAMPLE_PERIOD = 2500,
    parameter int unsigned MIDSCALE      = 2048,
    parameter int unsigned DECAY_PERIOD  = 250,
    parameter int unsigned DECAY_STEP    = 1
) (
    input  logic              clk,
    input  logic              reset,
    vu_level_meter_if.master  bus
);

    localparam int TW = $clog2(SAMPLE_PERIOD);
    localparam int CW = $clog2(CLK_DIV + 1);
    localparam int DW = $clog2(DECAY_PERIOD + 1);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        SHIFT,
        DONE
    } state_t;

    state_t        state;
    logic [TW-1:0] timer;
    logic [CW-1:0] div_cnt;
    logic [3:0]    bit_cnt;
    logic [11:0]   shreg;
    logic          cs_n_q;
    logic          sclk_q;
    logic [11:0]   code_q;
    logic [7:0]    scaled_q;
    logic          upd_q;

    logic [11:0]   sample_q;
    logic [7:0]    level_q;
    logic          valid_q;
    logic [DW-1:0] decay_cnt;

    logic [12:0]   diff;
    logic [12:0]   mag;
    logic [7:0]    scaled;
    logic [8:0]    lvl_sub;
    logic [7:0]    dec_level;

    // Only code 0 exceeds 2047 after rectification; clamp it to full scale.
    always_comb begin
        diff      = {1'b0, shreg} - 13'(MIDSCALE);
        mag       = diff[12] ? (~diff + 13'd1) : diff;
        scaled    = (mag > 13'd2047) ? 8'hFF : mag[10:3];
        lvl_sub   = {1'b0, level_q} - 9'(DECAY_STEP);
        dec_level = lvl_sub[8] ? 8'd0 : lvl_sub[7:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            timer    <= '0;
            div_cnt  <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            cs_n_q   <= 1'b1;
            sclk_q   <= 1'b1;
            code_q   <= '0;
            scaled_q <= '0;
            upd_q    <= 1'b0;
        end else begin
            timer <= (timer == TW'(SAMPLE_PERIOD - 1)) ? '0 : timer + 1'b1;
            upd_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (timer == '0) begin
                        state   <= SETUP;
                        cs_n_q  <= 1'b0;
                        div_cnt <= '0;
                    end
                end
                SETUP: begin
                    if (div_cnt == CW'(CLK_DIV - 1)) begin
                        div_cnt <= '0;
                        sclk_q  <= 1'b0;
                        bit_cnt <= '0;
                        state   <= SHIFT;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                SHIFT: begin
                    if (div_cnt == CW'(CLK_DIV - 1)) begin
                        div_cnt <= '0;
                        if (!sclk_q) begin
                            // leading frame bits fall off the top
                            sclk_q <= 1'b1;
                            shreg  <= {shreg[10:0], bus.adc_miso};
                        end else if (bit_cnt == 4'd15) begin
                            cs_n_q <= 1'b1;
                            state  <= DONE;
                        end else begin
                            sclk_q  <= 1'b0;
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                DONE: begin
                    code_q   <= shreg;
                    scaled_q <= scaled;
                    upd_q    <= 1'b1;
                    state    <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sample_q  <= '0;
            level_q   <= '0;
            valid_q   <= 1'b0;
            decay_cnt <= '0;
        end else begin
            valid_q <= upd_q;
            if (upd_q) begin
                sample_q <= code_q;
                if (scaled_q > level_q) begin
                    level_q   <= scaled_q;
                    decay_cnt <= '0;
                end else if (decay_cnt == DW'(DECAY_PERIOD - 1)) begin
                    level_q   <= dec_level;
                    decay_cnt <= '0;
                end else begin
                    decay_cnt <= decay_cnt + 1'b1;
                end
            end
        end
    end

    assign bus.adc_cs_n    = cs_n_q;
    assign bus.adc_sclk    = sclk_q;
    assign bus.sample      = sample_q;
    assign bus.level       = level_q;
    assign bus.level_valid = valid_q;

endmodule

// File: tb/tb_vu_level_meter.sv
// Bench for vu_level_meter: two instances, a serial ADC model each,
// and an envelope reference model built from plain integer arithmetic.
module tb_vu_level_meter;

    localparam int MID  = 2048;
    localparam int A_DP = 250;
    localparam int A_DS = 1;
    localparam int B_DP = 1;
    localparam int B_DS = 4;

    logic        clk = 1'b0;
    logic        reset_a = 1'b1;
    logic        reset_b = 1'b1;
    logic [11:0] code_a = '0;
    logic [11:0] code_b = '0;
    logic        miso_a = 1'b0;
    logic        miso_b = 1'b0;
    logic [15:0] frm_a;
    logic [15:0] frm_b;
    int          idx_a;
    int          idx_b;

    int checks = 0;
    int errors = 0;
    int m_lvl_a = 0;
    int m_cnt_a = 0;
    int m_lvl_b = 0;
    int m_cnt_b = 0;

    always #5 clk = ~clk;

    vu_level_meter_if bus_a ();
    vu_level_meter_if bus_b ();

    assign bus_a.adc_miso = miso_a;
    assign bus_b.adc_miso = miso_b;

    vu_level_meter #(
        .CLK_DIV(1), .SAMPLE_PERIOD(40), .MIDSCALE(MID),
        .DECAY_PERIOD(A_DP), .DECAY_STEP(A_DS)
    ) dut_a (
        .clk(clk), .reset(reset_a), .bus(bus_a)
    );

    vu_level_meter #(
        .CLK_DIV(4), .SAMPLE_PERIOD(2500), .MIDSCALE(MID),
        .DECAY_PERIOD(B_DP), .DECAY_STEP(B_DS)
    ) dut_b (
        .clk(clk), .reset(reset_b), .bus(bus_b)
    );

    // ADC models: random junk in the leading nibble, data changes on sclk fall
    always @(negedge bus_a.adc_cs_n) begin
        frm_a = {4'($urandom_range(0, 15)), code_a};
        idx_a = 16;
    end
    always @(negedge bus_a.adc_sclk) begin
        if (!bus_a.adc_cs_n && idx_a > 0) begin
            idx_a  = idx_a - 1;
            miso_a = frm_a[idx_a];
        end
    end
    always @(negedge bus_b.adc_cs_n) begin
        frm_b = {4'($urandom_range(0, 15)), code_b};
        idx_b = 16;
    end
    always @(negedge bus_b.adc_sclk) begin
        if (!bus_b.adc_cs_n && idx_b > 0) begin
            idx_b  = idx_b - 1;
            miso_b = frm_b[idx_b];
        end
    end

    function automatic int scaled_of(input int code);
        int amp;
        amp = code - MID;
        if (amp < 0) amp = -amp;
        if (amp > 2047) amp = 2047;
        return amp / 8;
    endfunction

    task automatic model_step(inout int lvl, inout int cnt,
                              input int code, input int dp, input int ds);
        int s;
        s = scaled_of(code);
        if (s > lvl) begin
            lvl = s;
            cnt = 0;
        end else if (cnt == dp - 1) begin
            lvl = (lvl > ds) ? lvl - ds : 0;
            cnt = 0;
        end else begin
            cnt = cnt + 1;
        end
    endtask

    task automatic a_reset();
        @(negedge clk);
        reset_a = 1'b1;
        repeat (3) @(negedge clk);
        m_lvl_a = 0;
        m_cnt_a = 0;
        reset_a = 1'b0;
    endtask

    task automatic b_reset();
        @(negedge clk);
        reset_b = 1'b1;
        repeat (3) @(negedge clk);
        m_lvl_b = 0;
        m_cnt_b = 0;
        reset_b = 1'b0;
    endtask

    task automatic a_step(input logic [11:0] code, output bit ok);
        code_a = code;
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (bus_a.level_valid === 1'b1) ok = 1'b1;
        end
        model_step(m_lvl_a, m_cnt_a, int'(code), A_DP, A_DS);
    endtask

    task automatic b_step(input logic [11:0] code, output bit ok);
        code_b = code;
        ok = 1'b0;
        for (int i = 0; i < 3000 && !ok; i++) begin
            @(negedge clk);
            if (bus_b.level_valid === 1'b1) ok = 1'b1;
        end
        model_step(m_lvl_b, m_cnt_b, int'(code), B_DP, B_DS);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks += 10;
        if (bus_a.adc_cs_n !== 1'b1) begin errors++;
            $display("FAIL rst_a_cs_n: got %b want 1", bus_a.adc_cs_n); end
        if (bus_a.adc_sclk !== 1'b1) begin errors++;
            $display("FAIL rst_a_sclk: got %b want 1", bus_a.adc_sclk); end
        if (bus_a.sample !== 12'd0) begin errors++;
            $display("FAIL rst_a_sample: got %h want 0", bus_a.sample); end
        if (bus_a.level !== 8'd0) begin errors++;
            $display("FAIL rst_a_level: got %0d want 0", bus_a.level); end
        if (bus_a.level_valid !== 1'b0) begin errors++;
            $display("FAIL rst_a_valid: got %b want 0", bus_a.level_valid); end
        if (bus_b.adc_cs_n !== 1'b1) begin errors++;
            $display("FAIL rst_b_cs_n: got %b want 1", bus_b.adc_cs_n); end
        if (bus_b.adc_sclk !== 1'b1) begin errors++;
            $display("FAIL rst_b_sclk: got %b want 1", bus_b.adc_sclk); end
        if (bus_b.sample !== 12'd0) begin errors++;
            $display("FAIL rst_b_sample: got %h want 0", bus_b.sample); end
        if (bus_b.level !== 8'd0) begin errors++;
            $display("FAIL rst_b_level: got %0d want 0", bus_b.level); end
        if (bus_b.level_valid !== 1'b0) begin errors++;
            $display("FAIL rst_b_valid: got %b want 0", bus_b.level_valid); end
    endtask

    task automatic test_frame_timing();
        int low_cnt = 0, rises = 0, nvalid = 0;
        int vidx = -1, fall2 = -1;
        bit first_low = 1'b0;
        logic prev_sclk = 1'b1, prev_cs = 1'b1;
        logic [7:0] vlevel = '0;
        logic [11:0] vsample = '0;
        code_b = 12'hFFF;
        m_lvl_b = 0;
        m_cnt_b = 0;
        reset_b = 1'b0;
        for (int k = 0; k <= 2500; k++) begin
            @(negedge clk);
            if (k == 0) first_low = (bus_b.adc_cs_n === 1'b0);
            if (k < 2400 && bus_b.adc_cs_n === 1'b0) low_cnt++;
            if (k < 2400 && bus_b.adc_sclk === 1'b1 && prev_sclk === 1'b0)
                rises++;
            if (bus_b.level_valid === 1'b1) begin
                nvalid++;
                if (vidx < 0) begin
                    vidx = k;
                    vlevel = bus_b.level;
                    vsample = bus_b.sample;
                end
            end
            if (k > 0 && bus_b.adc_cs_n === 1'b0 && prev_cs === 1'b1
                && fall2 < 0) fall2 = k;
            prev_sclk = bus_b.adc_sclk;
            prev_cs = bus_b.adc_cs_n;
        end
        model_step(m_lvl_b, m_cnt_b, 4095, B_DP, B_DS);
        checks += 8;
        if (!first_low) begin errors++;
            $display("FAIL first_cs_fall: cs_n not low on first cycle"); end
        if (low_cnt != 132) begin errors++;
            $display("FAIL cs_low_len: got %0d want 132", low_cnt); end
        if (rises != 16) begin errors++;
            $display("FAIL sclk_rises: got %0d want 16", rises); end
        if (vidx != 134) begin errors++;
            $display("FAIL valid_latency: got %0d want 134", vidx); end
        if (vsample !== 12'hFFF) begin errors++;
            $display("FAIL fff_sample: got %h want fff", vsample); end
        if (vlevel !== 8'd255) begin errors++;
            $display("FAIL fff_level: got %0d want 255", vlevel); end
        if (nvalid != 1) begin errors++;
            $display("FAIL valid_pulses: got %0d want 1", nvalid); end
        if (fall2 != 2500) begin errors++;
            $display("FAIL sample_period: got %0d want 2500", fall2); end
    endtask

    task automatic test_reset_midframe();
        int rises = 0, vidx = -1, nval = 0;
        bit ok = 1'b0, low0 = 1'b0;
        logic prev = 1'b1;
        logic [7:0] vlevel = '0;
        logic [11:0] newc;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(negedge clk);
            if (bus_b.adc_sclk === 1'b1 && prev === 1'b0) rises++;
            prev = bus_b.adc_sclk;
            if (rises == 8) ok = 1'b1;
        end
        checks += 2;
        if (!ok) begin errors++;
            $display("FAIL mid_8th_rise: got %0d rises want 8", rises); end
        if (bus_b.level !== 8'(m_lvl_b)) begin errors++;
            $display("FAIL mid_pre_level: got %0d want %0d",
                     bus_b.level, m_lvl_b); end
        reset_b = 1'b1;
        @(negedge clk);
        checks += 4;
        if (bus_b.adc_cs_n !== 1'b1) begin errors++;
            $display("FAIL mid_cs_n: got %b want 1", bus_b.adc_cs_n); end
        if (bus_b.adc_sclk !== 1'b1) begin errors++;
            $display("FAIL mid_sclk: got %b want 1", bus_b.adc_sclk); end
        if (bus_b.level !== 8'd0) begin errors++;
            $display("FAIL mid_level: got %0d want 0", bus_b.level); end
        if (bus_b.level_valid !== 1'b0) begin errors++;
            $display("FAIL mid_valid: got %b want 0", bus_b.level_valid); end
        repeat (3) begin
            @(negedge clk);
            if (bus_b.level_valid === 1'b1) nval++;
        end
        m_lvl_b = 0;
        m_cnt_b = 0;
        newc = 12'($urandom_range(0, 4095));
        code_b = newc;
        reset_b = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (k == 0) low0 = (bus_b.adc_cs_n === 1'b0);
            if (bus_b.level_valid === 1'b1) begin
                nval++;
                if (vidx < 0) begin
                    vidx = k;
                    vlevel = bus_b.level;
                end
            end
        end
        model_step(m_lvl_b, m_cnt_b, int'(newc), B_DP, B_DS);
        checks += 4;
        if (!low0) begin errors++;
            $display("FAIL restart_cs: cs_n not low on first cycle"); end
        if (vidx != 134) begin errors++;
            $display("FAIL restart_latency: got %0d want 134", vidx); end
        if (vlevel !== 8'(m_lvl_b)) begin errors++;
            $display("FAIL restart_level: got %0d want %0d",
                     vlevel, m_lvl_b); end
        if (nval != 1) begin errors++;
            $display("FAIL restart_pulses: got %0d want 1", nval); end
    endtask

    task automatic test_decay_floor();
        bit ok;
        int exp_lv[4] = '{6, 2, 0, 0};
        logic [11:0] cd[4] = '{12'd2096, 12'h800, 12'h800, 12'h800};
        b_reset();
        for (int i = 0; i < 4; i++) begin
            b_step(cd[i], ok);
            checks += 3;
            if (!ok) begin errors++;
                $display("FAIL floor_timeout: step %0d", i); end
            if (bus_b.level !== 8'(exp_lv[i])) begin errors++;
                $display("FAIL floor_level: step %0d got %0d want %0d",
                         i, bus_b.level, exp_lv[i]); end
            if (m_lvl_b != exp_lv[i]) begin errors++;
                $display("FAIL floor_model: step %0d got %0d want %0d",
                         i, m_lvl_b, exp_lv[i]); end
        end
    endtask

    task automatic test_midscale_and_saturation();
        bit ok;
        a_reset();
        a_step(12'h800, ok);
        checks += 3;
        if (!ok) begin errors++; $display("FAIL mid_timeout"); end
        if (bus_a.level !== 8'd0) begin errors++;
            $display("FAIL mid_level0: got %0d want 0", bus_a.level); end
        if (bus_a.sample !== 12'h800) begin errors++;
            $display("FAIL mid_sample: got %h want 800", bus_a.sample); end
        a_reset();
        a_step(12'h000, ok);
        checks += 3;
        if (!ok) begin errors++; $display("FAIL sat_timeout"); end
        if (bus_a.level !== 8'd255) begin errors++;
            $display("FAIL sat_level: got %0d want 255", bus_a.level); end
        if (bus_a.sample !== 12'h000) begin errors++;
            $display("FAIL sat_sample: got %h want 000", bus_a.sample); end
        a_step(12'hFFF, ok);
        checks += 2;
        if (bus_a.level !== 8'd255) begin errors++;
            $display("FAIL fs_level: got %0d want 255", bus_a.level); end
        if (bus_a.sample !== 12'hFFF) begin errors++;
            $display("FAIL fs_sample: got %h want fff", bus_a.sample); end
    endtask

    task automatic test_decay();
        bit ok;
        a_reset();
        a_step(12'hC00, ok);
        checks += 2;
        if (!ok) begin errors++; $display("FAIL c00_timeout"); end
        if (bus_a.level !== 8'd128) begin errors++;
            $display("FAIL c00_level: got %0d want 128", bus_a.level); end
        for (int n = 1; n <= 500; n++) begin
            a_step(12'h800, ok);
            checks += 2;
            if (!ok) begin errors++;
                $display("FAIL decay_timeout: update %0d", n); end
            if (bus_a.level !== 8'(m_lvl_a)) begin errors++;
                $display("FAIL decay_model: update %0d got %0d want %0d",
                         n, bus_a.level, m_lvl_a); end
            if (n == 249 || n == 250 || n == 500) begin
                checks++;
                if (bus_a.level !== ((n == 249) ? 8'd128 :
                                     (n == 250) ? 8'd127 : 8'd126)) begin
                    errors++;
                    $display("FAIL decay_point: update %0d got %0d",
                             n, bus_a.level);
                end
            end
        end
    endtask

    task automatic test_peak_during_decay();
        bit ok;
        a_reset();
        a_step(12'd2848, ok);
        checks += 2;
        if (!ok) begin errors++; $display("FAIL pk_timeout"); end
        if (bus_a.level !== 8'd100) begin errors++;
            $display("FAIL pk_level100: got %0d want 100", bus_a.level); end
        a_step(12'd2848, ok);
        checks++;
        if (bus_a.level !== 8'd100) begin errors++;
            $display("FAIL pk_equal: got %0d want 100", bus_a.level); end
        for (int n = 0; n < 248; n++) begin
            a_step(12'h800, ok);
            checks++;
            if (bus_a.level !== 8'(m_lvl_a)) begin errors++;
                $display("FAIL pk_hold: update %0d got %0d want %0d",
                         n, bus_a.level, m_lvl_a); end
        end
        a_step(12'd3248, ok);
        checks++;
        if (bus_a.level !== 8'd150) begin errors++;
            $display("FAIL pk_new_peak: got %0d want 150", bus_a.level); end
        for (int n = 1; n <= 250; n++) begin
            a_step(12'h800, ok);
            checks++;
            if (bus_a.level !== ((n < 250) ? 8'd150 : 8'd149)) begin
                errors++;
                $display("FAIL pk_counter_clear: update %0d got %0d",
                         n, bus_a.level);
            end
        end
    endtask

    task automatic test_random();
        bit ok;
        logic [11:0] c;
        a_reset();
        for (int n = 0; n < 150; n++) begin
            if ($urandom_range(0, 3) == 0)
                c = 12'($urandom_range(0, 4095));
            else
                c = 12'(MID - 100 + int'($urandom_range(0, 200)));
            a_step(c, ok);
            checks += 3;
            if (!ok) begin errors++;
                $display("FAIL rnd_timeout: update %0d", n); end
            if (bus_a.level !== 8'(m_lvl_a)) begin errors++;
                $display("FAIL rnd_level: code %h got %0d want %0d",
                         c, bus_a.level, m_lvl_a); end
            if (bus_a.sample !== c) begin errors++;
                $display("FAIL rnd_sample: got %h want %h",
                         bus_a.sample, c); end
        end
    endtask

    initial begin
        test_reset();
        test_frame_timing();
        test_reset_midframe();
        test_decay_floor();
        test_midscale_and_saturation();
        test_decay();
        test_peak_during_decay();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
